// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the PC, issues one aligned 64-bit read at a time and
// hands each 32-bit half to decode. Optional macro FETCH_HALT_ON_ZERO_EN stops at a zero word.
module fetch_sequencer #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] entry_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_SLOT0 = 3'd3,
    S_SLOT1 = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [63:0]       line;
  logic [31:0]       slot_word;
  logic              in_slot;
  logic              slot_zero;
  logic              fire;
  logic              launch;

  always_comb begin
    in_slot   = (state == S_SLOT0) || (state == S_SLOT1);
    slot_word = (state == S_SLOT1) ? line[63:32] : line[31:0];
`ifdef FETCH_HALT_ON_ZERO_EN
    slot_zero = in_slot && (slot_word == 32'h0000_0000);
`else
    slot_zero = 1'b0;
`endif
    fire      = in_slot && !slot_zero && inst_ready;
    launch    = ((state == S_IDLE) || (state == S_HALT)) && start;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_HALT: if (start) state_nxt = S_REQ;
      S_REQ:          if (mem_gnt) state_nxt = S_WAIT;
      // A start address in the upper half of a doubleword skips the lower slot.
      S_WAIT:         if (mem_rvalid) state_nxt = pc[2] ? S_SLOT1 : S_SLOT0;
      S_SLOT0: begin
        if (slot_zero)       state_nxt = S_HALT;
        else if (inst_ready) state_nxt = S_SLOT1;
      end
      S_SLOT1: begin
        if (slot_zero)       state_nxt = S_HALT;
        else if (inst_ready) state_nxt = S_REQ;
      end
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc   <= '0;
      line <= '0;
    end else begin
      if (launch) begin
        pc <= {entry_pc[ADDR_W-1:2], 2'b00};
      end else if (fire) begin
        pc <= pc + ADDR_W'(4);
      end
      if ((state == S_WAIT) && mem_rvalid) begin
        line <= mem_rdata;
      end
    end
  end

  always_comb begin
    mem_req    = (state == S_REQ);
    mem_addr   = {pc[ADDR_W-1:3], 3'b000};
    inst_valid = in_slot && !slot_zero;
    inst       = slot_word;
    inst_pc    = pc;
    busy       = (state != S_IDLE) && (state != S_HALT);
`ifdef FETCH_HALT_ON_ZERO_EN
    halted     = (state == S_HALT);
`else
    halted     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: alignment, backpressure, slow memory, reset, wrap, zero words.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] entry_pc;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready;
  logic        busy;
  logic        halted;

  int total = 0;
  int bad   = 0;

  fetch_sequencer #(.ADDR_W(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .entry_pc   (entry_pc),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .busy       (busy),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; entry_pc = '0; mem_gnt = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0; inst_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_mem_req",    64'(mem_req),    64'd0);
    chk("rst_mem_addr",   mem_addr,        64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst",       64'(inst),       64'd0);
    chk("rst_inst_pc",    inst_pc,         64'd0);
    chk("rst_busy",       64'(busy),       64'd0);
    chk("rst_halted",     64'(halted),     64'd0);

    // Aligned start at 0x1000
    start = 1'b1; entry_pc = 64'h1000;
    tick();
    start = 1'b0;
    chk("t1_req",  64'(mem_req), 64'd1);
    chk("t1_addr", mem_addr,     64'h1000);
    chk("t1_busy", 64'(busy),    64'd1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("t1_wait_noreq", 64'(mem_req),    64'd0);
    chk("t1_wait_noval", 64'(inst_valid), 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 64'h00500093_00000513;
    tick();
    mem_rvalid = 1'b0;
    chk("t1_s0_valid", 64'(inst_valid), 64'd1);
    chk("t1_s0_inst",  64'(inst),       64'h00000513);
    chk("t1_s0_pc",    inst_pc,         64'h1000);
    inst_ready = 1'b1;
    tick();
    chk("t1_s1_valid", 64'(inst_valid), 64'd1);
    chk("t1_s1_inst",  64'(inst),       64'h00500093);
    chk("t1_s1_pc",    inst_pc,         64'h1004);
    tick();
    inst_ready = 1'b0;
    chk("t1_next_req",  64'(mem_req),    64'd1);
    chk("t1_next_addr", mem_addr,        64'h1008);
    chk("t1_next_nval", 64'(inst_valid), 64'd0);

    // Unaligned start: low bits ignored, only the upper slot is issued
    reset = 1'b1; #1; reset = 1'b0;
    tick();
    start = 1'b1; entry_pc = 64'h1006;
    tick();
    start = 1'b0;
    chk("t2_addr", mem_addr, 64'h1000);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'hAAAABBBB_CCCCDDDD;
    tick();
    mem_rvalid = 1'b0;
    chk("t2_valid", 64'(inst_valid), 64'd1);
    chk("t2_inst",  64'(inst),       64'hAAAABBBB);
    chk("t2_pc",    inst_pc,         64'h1004);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("t2_next_req",  64'(mem_req), 64'd1);
    chk("t2_next_addr", mem_addr,     64'h1008);

    // Decoder backpressure in SLOT0
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'h11111111_22222222;
    tick();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_valid", 64'(inst_valid), 64'd1);
      chk("t3_stall_inst",  64'(inst),       64'h22222222);
      chk("t3_stall_pc",    inst_pc,         64'h1008);
      tick();
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("t3_s1_inst", 64'(inst), 64'h11111111);
    chk("t3_s1_pc",   inst_pc,   64'h100C);
    tick();
    chk("t3_once_pc",    inst_pc,         64'h100C);
    chk("t3_once_valid", 64'(inst_valid), 64'd1);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("t3_next_addr", mem_addr, 64'h1010);

    // Slow grant and slow read data
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_req",  64'(mem_req), 64'd1);
      chk("t4_hold_addr", mem_addr,     64'h1010);
      tick();
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t4_nodup_req", 64'(mem_req),    64'd0);
      chk("t4_wait_nval", 64'(inst_valid), 64'd0);
      tick();
    end
    mem_rvalid = 1'b1; mem_rdata = 64'h44444444_33333333;
    tick();
    mem_rvalid = 1'b0;
    chk("t4_valid", 64'(inst_valid), 64'd1);
    chk("t4_inst",  64'(inst),       64'h33333333);
    chk("t4_pc",    inst_pc,         64'h1010);

    // Reset while a read is outstanding, then a stray beat
    inst_ready = 1'b1;
    tick(); tick();
    inst_ready = 1'b0;
    chk("t5_req_addr", mem_addr, 64'h1018);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    reset = 1'b1;
    #1;
    chk("t5_rst_req",  64'(mem_req), 64'd0);
    chk("t5_rst_busy", 64'(busy),    64'd0);
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'h77777777_88888888;
    tick();
    mem_rvalid = 1'b0;
    tick();
    chk("t5_stray_nval", 64'(inst_valid), 64'd0);
    chk("t5_stray_busy", 64'(busy),       64'd0);
    chk("t5_stray_pc",   inst_pc,         64'd0);
    chk("t5_stray_req",  64'(mem_req),    64'd0);

    // PC wrap at the top of the address space
    start = 1'b1; entry_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    start = 1'b0;
    chk("t6_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'h55555555_66666666;
    tick();
    mem_rvalid = 1'b0;
    chk("t6_inst", 64'(inst), 64'h55555555);
    chk("t6_pc",   inst_pc,   64'hFFFF_FFFF_FFFF_FFFC);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("t6_wrap_req",  64'(mem_req), 64'd1);
    chk("t6_wrap_addr", mem_addr,     64'd0);

    // Zero word following an instruction
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'h00000000_00A00593;
    tick();
    mem_rvalid = 1'b0;
    chk("t7_s0_valid", 64'(inst_valid), 64'd1);
    chk("t7_s0_inst",  64'(inst),       64'h00A00593);
    chk("t7_s0_pc",    inst_pc,         64'd0);
    inst_ready = 1'b1;
    tick();
`ifdef FETCH_HALT_ON_ZERO_EN
    chk("t7_zero_nval", 64'(inst_valid), 64'd0);
    tick();
    inst_ready = 1'b0;
    chk("t7_halted",   64'(halted),     64'd1);
    chk("t7_hlt_busy", 64'(busy),       64'd0);
    chk("t7_hlt_nval", 64'(inst_valid), 64'd0);
    chk("t7_hlt_pc",   inst_pc,         64'd4);
    start = 1'b1; entry_pc = 64'h2000;
    tick();
    start = 1'b0;
    chk("t7_restart_req",  64'(mem_req), 64'd1);
    chk("t7_restart_addr", mem_addr,     64'h2000);
    chk("t7_restart_hlt",  64'(halted),  64'd0);
`else
    inst_ready = 1'b0;
    chk("t7_zero_valid", 64'(inst_valid), 64'd1);
    chk("t7_zero_inst",  64'(inst),       64'd0);
    chk("t7_zero_pc",    inst_pc,         64'd4);
    chk("t7_no_halt",    64'(halted),     64'd0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("t7_next_req",  64'(mem_req), 64'd1);
    chk("t7_next_addr", mem_addr,     64'd8);
`endif

    // start while busy is ignored
    start = 1'b1; entry_pc = 64'h3000;
    tick();
    start = 1'b0;
    chk("t8_ign_req", 64'(mem_req), 64'd1);
`ifdef FETCH_HALT_ON_ZERO_EN
    chk("t8_ign_addr", mem_addr, 64'h2000);
`else
    chk("t8_ign_addr", mem_addr, 64'd8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch sequencer feeding the RV64 instruction decoder. It walks a program counter from a start address, issues one 64-bit aligned read at a time to the memory port, and splits each returned doubleword into two 32-bit instructions. Each instruction is presented with its PC to the decode stage over a valid/ready handshake. It sits between the memory/bus interface and the decoder, and it is the only block that advances the fetch PC.

## Interface
- `ADDR_W`, 64, width of PC and memory address.
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins fetching at `entry_pc`.
- `entry_pc`  in  ADDR_W  first instruction address; bits [1:0] are ignored and treated as 0.
- `mem_req`  out  1  read request; held until granted.
- `mem_addr`  out  ADDR_W  request address, always 8-byte aligned (`{pc[ADDR_W-1:3],3'b000}`).
- `mem_gnt`  in  1  request accepted when `mem_req && mem_gnt`.
- `mem_rvalid`  in  1  read data valid, one beat per granted request.
- `mem_rdata`  in  64  read data; bits [31:0] hold the instruction at the lower address.
- `inst_valid`  out  1  instruction offered to the decoder.
- `inst`  out  32  instruction word.
- `inst_pc`  out  ADDR_W  address of `inst`.
- `inst_ready`  in  1  the decoder accepts when `inst_valid && inst_ready`.
- `busy`  out  1  high in every state except IDLE and HALT.
- `halted`  out  1  high in HALT.

## Operation
- States: IDLE, REQ, WAIT, SLOT0, SLOT1, HALT. Registers: `pc`, the 64-bit `line`, and the state.
- IDLE: when `start` is seen, `pc <= {entry_pc[ADDR_W-1:2],2'b00}` and the state goes to REQ.
- REQ: `mem_req=1`. When `mem_gnt` is seen, go to WAIT.
- WAIT: when `mem_rvalid` is seen, `line <= mem_rdata`. Go to SLOT0 if `pc[2]==0`, otherwise go to SLOT1. This handles a start address that is not doubleword aligned.
- SLOT0: `inst=line[31:0]`, `inst_pc=pc`. On handshake, `pc <= pc+4` and go to SLOT1.
- SLOT1: `inst=line[63:32]`, `inst_pc=pc`. On handshake, `pc <= pc+4` and go to REQ.
- HALT: hold until `start`, which restarts exactly as from IDLE.
- Only one memory request is outstanding at a time. `mem_rvalid` outside WAIT is ignored.
- `start` is ignored in REQ, WAIT, SLOT0 and SLOT1.
- `pc` arithmetic is modulo 2^ADDR_W. `pc=2^ADDR_W-4` increments to 0 with no error.
- `inst`/`inst_pc` hold stable while `inst_valid && !inst_ready`.

## Timing
- Reset values: state IDLE, `pc=0`, `line=0`, `mem_req=0`, `mem_addr=0`, `inst_valid=0`, `inst=0`, `inst_pc=0`, `busy=0`, `halted=0`.
- All outputs are decoded from registered state. There are no combinational paths from inputs to outputs.
- Latency:
  - `start` in cycle N gives `mem_req` in N+1.
  - A grant in cycle G gives WAIT from G+1.
  - `rvalid` in cycle R gives `inst_valid` in R+1.
- With `inst_ready` tied high and the memory granting immediately, the best-case throughput is 2 instructions per 4 cycles (REQ, WAIT, SLOT0, SLOT1).
- Reset asserted mid-operation: return to IDLE immediately and drop the outstanding request. A late `rvalid` after reset is ignored.

## Configuration
- `FETCH_HALT_ON_ZERO_EN`
  - Defined: in SLOT0/SLOT1, if the slot word equals 32'h0000_0000, `inst_valid` stays 0, `pc` is not advanced, and the next state is HALT (`halted=1`). This terminates decode at the zero padding following a program.
  - Undefined: zero words are presented as ordinary instructions, HALT is unreachable, and `halted` is tied to 0.

## Test plan
- Reset, then `start` with `entry_pc=0x1000`, memory returns 0x00500093_00000513 → two handshakes: (`inst=0x00000513`, `inst_pc=0x1000`) then (`0x00500093`, `0x1004`); next `mem_addr=0x1008`.
- `entry_pc=0x1004` → `mem_addr=0x1000`; only `line[63:32]` is issued, with `inst_pc=0x1004`; next request goes to 0x1008.
- `inst_ready` held low for 5 cycles in SLOT0 → `inst`/`inst_pc` stay constant and `pc` is unchanged; it advances exactly once when `inst_ready` rises.
- `mem_gnt` delayed 3 cycles and `rvalid` delayed 4 → `mem_req` and `mem_addr` are held steady, there is no duplicate request, and `inst_valid` rises the cycle after `rvalid`.
- `reset` asserted in WAIT, then a stray `rvalid` → state IDLE, `inst_valid=0`, and no instruction is emitted.
- With `FETCH_HALT_ON_ZERO_EN`, returned data 0x00000000_00A00593 → one instruction is issued (`0x00A00593`), then `halted=1`, `busy=0`, `inst_valid=0`. A new `start` restarts fetching.
